// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame FSM encoding,
// frame geometry and default sizing of the receive buffer.
package ps2_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int PS2_FRAME_BITS     = 11;
    localparam int PS2_DATA_BITS      = 8;
    localparam int PS2_ADDR_W         = 5;
    localparam int PS2_FILTER_LEN     = 4;
    localparam int PS2_TIMEOUT_CYCLES = 50000;
endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines, deglitches the clock line and emits a
// one-cycle strobe with the sampled data bit on each filtered falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic strobe_o,
    output logic data_sync_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q, data_q;

    // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = ~filt_q;
            else                              cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            data_q     <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            strobe_q   <= filt_q & ~filt_d;
            data_q     <= dat_sync_q[1];
        end
    end

    assign strobe_o    = strobe_q;
    assign data_sync_o = data_q;
endmodule

// File: rtl/ps2_rx_buffer_controller.sv
// PS/2 keyboard receiver: frame FSM with watchdog feeding a circular byte
// FIFO with sticky frame-error and overflow flags.
module ps2_rx_buffer_controller
    import ps2_pkg::*;
#(
    parameter int ADDR_W         = PS2_ADDR_W,
    parameter int FILTER_LEN     = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic                system_clk,
    input  logic                reset,
    input  logic                PS2_clk,
    input  logic                PS2_data,
    input  logic                read,
    input  logic                clear_flags,
    output logic [7:0]          out,
    output logic                empty,
    output logic                full,
    output logic [ADDR_W:0]     count,
    output logic                frame_error,
    output logic                overflow
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic strobe, bit_in;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk_i       (system_clk),
        .rst_i       (reset),
        .ps2_clk_i   (PS2_clk),
        .ps2_data_i  (PS2_data),
        .strobe_o    (strobe),
        .data_sync_o (bit_in)
    );

    ps2_state_e               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     parity_ok_q, parity_ok_d;
    logic [WDW-1:0]           wdog_q, wdog_d;
    logic                     push, frame_fault;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        wdog_d      = '0;
        push        = 1'b0;
        frame_fault = 1'b0;
        if (strobe) begin
            unique case (state_q)
                ST_IDLE: if (!bit_in) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
                ST_DATA: begin
                    shift_d   = {bit_in, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_ok_d = ^shift_q ^ bit_in;
                    state_d     = ST_STOP;
                end
                ST_STOP: begin
                    if (bit_in && parity_ok_q) push        = 1'b1;
                    else                       frame_fault = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // Watchdog only runs mid-frame; a stalled frame is abandoned.
            if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = ST_IDLE;
                shift_d     = '0;
                frame_fault = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
            wdog_q      <= wdog_d;
        end
    end

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        out_q, out_d;
    logic              do_push, do_pop, ovf_set, is_full;

    // out_q mirrors mem[rd_ptr]; the pushed byte bypasses when it becomes the head.
    always_comb begin
        is_full = (count_q == FULL_CNT);
        do_pop  = read && (count_q != '0);
        do_push = push && (!is_full || do_pop);
        ovf_set = push && is_full && !do_pop;
        rd_nxt  = rd_ptr_q + 1'b1;
        count_d = count_q;
        out_d   = out_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
        if (do_push && count_q == '0)                out_d = shift_q;
        else if (do_pop && count_q > 1)              out_d = mem[rd_nxt];
        else if (do_pop && do_push && count_q == 1)  out_d = shift_q;
    end

    always_ff @(posedge system_clk) begin
        if (do_push) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= 8'h00;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_nxt;
            count_q     <= count_d;
            out_q       <= out_d;
            frame_error <= frame_fault | (frame_error & ~clear_flags);
            overflow    <= ovf_set | (overflow & ~clear_flags);
        end
    end

    assign out   = out_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = is_full;
endmodule

// File: tb/tb_ps2_rx_buffer_controller.sv
// Directed and randomized frames against a queue-based model of the receive buffer.
module tb_ps2_rx_buffer_controller;
    import ps2_pkg::*;

    localparam int TO = 300;
    localparam int H  = 20;

    logic       system_clk = 1'b0;
    logic       reset = 1'b1, PS2_clk = 1'b1, PS2_data = 1'b1, read = 1'b0, clear_flags = 1'b0;
    logic [7:0] out;
    logic       empty, full, frame_error, overflow;
    logic [5:0] count;

    int n_assert = 0, n_fail = 0;
    logic [7:0] mq[$];
    bit m_ferr = 0, m_ovf = 0;

    always #5 system_clk = ~system_clk;

    ps2_rx_buffer_controller #(.ADDR_W(5), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .system_clk(system_clk), .reset(reset), .PS2_clk(PS2_clk), .PS2_data(PS2_data),
        .read(read), .clear_flags(clear_flags), .out(out), .empty(empty), .full(full),
        .count(count), .frame_error(frame_error), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, ".count"}, 32'(count), 32'(mq.size()));
        chk({step, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({step, ".full"}, 32'(full), 32'(mq.size() == 32));
        chk({step, ".frame_error"}, 32'(frame_error), 32'(m_ferr));
        chk({step, ".overflow"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk({step, ".out"}, 32'(out), 32'(mq[0]));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge system_clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            PS2_data = f[i];
            cycles(H);
            PS2_clk = 1'b0;
            cycles(H);
            PS2_clk = 1'b1;
        end
    endtask

    // Model: a frame is accepted iff start=0, odd parity over data+parity, stop=1.
    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f = mk_frame(b, bad_par);
        send_bits(f, 0, PS2_FRAME_BITS - 1);
        if (f[0] == 1'b0 && (^f[9:1]) == 1'b1 && f[10] == 1'b1) begin
            if (mq.size() < 32) mq.push_back(f[8:1]);
            else                m_ovf = 1;
        end else begin
            m_ferr = 1;
        end
        PS2_data = 1'b1;
        cycles(10);
    endtask

    task automatic do_read();
        read = 1'b1;
        cycles(1);
        read = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic do_clear();
        clear_flags = 1'b1;
        cycles(1);
        clear_flags = 1'b0;
        m_ferr = 0;
        m_ovf  = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        mq.delete();
        m_ferr = 0;
        m_ovf  = 0;
    endtask

    initial begin
        cycles(3);
        do_reset();
        check_all("reset");
        chk("reset.out", 32'(out), 32'h00);

        send_frame(8'h1C, 0);
        check_all("single");
        do_read();
        check_all("single_read");

        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check_all("pair");
        do_read();
        check_all("pair_read1");
        do_read();
        check_all("pair_read2");

        send_frame(8'h1C, 1);
        check_all("bad_parity");
        do_clear();
        check_all("bad_parity_clear");

        // Idle glitch with data low: a spurious strobe would start a bogus frame.
        PS2_data = 1'b0;
        PS2_clk  = 1'b0;
        cycles(2);
        PS2_clk  = 1'b1;
        cycles(10);
        PS2_data = 1'b1;
        cycles(10);
        check_all("glitch");
        send_frame(8'h3A, 0);
        check_all("after_glitch");
        do_read();

        for (int i = 0; i <= 32; i++) send_frame(8'(i), 0);
        check_all("fill");
        chk("fill.out", 32'(out), 32'h00);
        for (int i = 0; i < 32; i++) begin
            chk("drain.out", 32'(out), 32'(i));
            do_read();
            check_all("drain");
        end
        do_read();
        check_all("read_empty");
        do_clear();
        check_all("fill_clear");

        // Stall after four data bits: watchdog must abort the frame.
        send_bits(mk_frame(8'hA5, 0), 0, 4);
        cycles(TO + 60);
        m_ferr = 1;
        check_all("timeout");
        do_clear();
        send_frame(8'h5A, 0);
        check_all("after_timeout");
        do_read();

        for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 0);
        check_all("pre_reset");
        send_bits(mk_frame(8'hC0, 0), 0, 6);
        do_reset();
        check_all("mid_reset");
        send_bits(mk_frame(8'hC0, 0), 7, 10);
        cycles(10);
        check_all("reset_tail");
        send_frame(8'h1C, 0);
        check_all("after_reset");
        do_read();

        for (int i = 0; i < 25; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, $urandom_range(0, 4) == 0);
            check_all("rand_frame");
            if ($urandom_range(0, 2) == 0) begin
                do_read();
                check_all("rand_read");
            end
            if (m_ferr && $urandom_range(0, 1) == 0) begin
                do_clear();
                check_all("rand_clear");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
